controle_execucao: RTL

Run/pause/single-step sequencer for the lab CPU, driven by board push-buttons. Conditions three buttons: 2-FF sync, optional debounce, rising-edge detect. Runs an FSM that drives the CPU clock-enable and CPU reset. Reacts to the CPU halt flag, counts executed cycles and enforces an optional cycle-limit watchdog.

---
 rtl/controle_execucao_pkg.sv | 16 +
 rtl/controle_execucao_botao.sv | 67 ++++++
 rtl/controle_execucao.sv | 98 +++++++++
 3 files changed

// File: rtl/controle_execucao_pkg.sv
// Shared state codes and defaults for the run/pause/step sequencer.
// Optional debounce is enabled by defining CTRL_DEBOUNCE_EN.
package controle_execucao_pkg;

  localparam int ST_W = 3;
  localparam int DEBOUNCE_DEF = 16;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_PAUSE  = 3'd2,
    ST_STEP   = 3'd3,
    ST_HALTED = 3'd4
  } state_t;

endpackage

// File: rtl/controle_execucao_botao.sv
// Button conditioner: 2-FF sync, optional debounce, rising-edge pulse.
// Debounce filter is built only when CTRL_DEBOUNCE_EN is defined.
module condiciona_botao
  import controle_execucao_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic pulse_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic level;

  // Two-flop synchronizer for the raw button.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef CTRL_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic          filt_q;

  // Filtered level flips after enough consecutive differing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else if (sync2_q != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        cnt_q  <= '0;
        filt_q <= sync2_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end else begin
      cnt_q <= '0;
    end
  end

  assign level = filt_q;
`else
  assign level = sync2_q;
`endif

  // Previous level for one-cycle rising-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev_q <= 1'b0;
    else       prev_q <= level;
  end

  assign pulse_o = level & ~prev_q;

endmodule

// File: rtl/controle_execucao.sv
// Run/pause/single-step sequencer with cycle counter and watchdog.
// Define CTRL_DEBOUNCE_EN to add debounce filtering on the buttons.
module controle_execucao
  import controle_execucao_pkg::*;
#(
  parameter int CYCLE_W         = 32,
  parameter int MAX_CYCLES      = 0,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_btn,
  input  logic               pause_btn,
  input  logic               step_btn,
  input  logic               halt_in,
  output logic               cpu_en,
  output logic               cpu_rst,
  output logic [ST_W-1:0]    state,
  output logic [CYCLE_W-1:0] cycle_count,
  output logic               timeout
);

  localparam logic WD_EN = (MAX_CYCLES > 0);
  localparam logic [CYCLE_W-1:0] WD_LAST = CYCLE_W'(MAX_CYCLES - 1);

  state_t             state_q;
  state_t             state_d;
  logic               cpu_rst_q;
  logic [CYCLE_W-1:0] cycle_q;
  logic               timeout_q;
  logic               start_p;
  logic               pause_p;
  logic               step_p;
  logic               wd_hit;

  condiciona_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
    .clk(clk), .reset(reset), .btn_i(start_btn), .pulse_o(start_p)
  );
  condiciona_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause (
    .clk(clk), .reset(reset), .btn_i(pause_btn), .pulse_o(pause_p)
  );
  condiciona_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
    .clk(clk), .reset(reset), .btn_i(step_btn), .pulse_o(step_p)
  );

  assign cpu_en = ((state_q == ST_RUN) || (state_q == ST_STEP))
                  && !halt_in;
  assign wd_hit = WD_EN && cpu_en && (cycle_q == WD_LAST);

  // Next state; halt beats watchdog beats pause beats step beats start.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start_p) state_d = ST_RUN;
      ST_RUN: begin
        if (halt_in)      state_d = ST_HALTED;
        else if (wd_hit)  state_d = ST_HALTED;
        else if (pause_p) state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (step_p)       state_d = ST_STEP;
        else if (start_p) state_d = ST_RUN;
      end
      ST_STEP: begin
        if (halt_in || wd_hit) state_d = ST_HALTED;
        else                   state_d = ST_PAUSE;
      end
      ST_HALTED: if (start_p) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State, registered CPU reset, saturating counter and sticky timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cpu_rst_q <= 1'b1;
      cycle_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cpu_rst_q <= (state_d == ST_IDLE);
      if (state_d == ST_IDLE) begin
        cycle_q   <= '0;
        timeout_q <= 1'b0;
      end else begin
        if (cpu_en && (cycle_q != '1)) cycle_q <= cycle_q + 1'b1;
        if (wd_hit) timeout_q <= 1'b1;
      end
    end
  end

  assign state       = state_q;
  assign cpu_rst     = cpu_rst_q;
  assign cycle_count = cycle_q;
  assign timeout     = timeout_q;

endmodule
